// File: rtl/light_track.sv
// Tug-of-war light game: each key press drags the lit position one step toward
// that player; pushing it off your own end wins the round and flashes the playfield.
module light_track #(
    parameter int N_LIGHTS = 9,
    parameter int SCORE_W  = 3,
    parameter int WIN_HOLD = 4
) (
    input  logic                Clock,
    input  logic                RST,
    input  logic                L,
    input  logic                R,
    output logic [N_LIGHTS-1:0] lights,
    output logic [1:0]          winner,
    output logic                game_over,
    output logic [SCORE_W-1:0]  left_score,
    output logic [SCORE_W-1:0]  right_score,
    output logic [1:0]          dbgState
);

    localparam int PW     = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1;
    localparam int HW     = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;
    localparam int CENTER = (N_LIGHTS - 1) / 2;

    localparam logic [PW-1:0]      POS_CENTER = PW'(CENTER);
    localparam logic [PW-1:0]      POS_MAX    = PW'(N_LIGHTS - 1);
    localparam logic [HW-1:0]      HOLD_LAST  = HW'(WIN_HOLD - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        WIN_L = 2'd1,
        WIN_R = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] pos;
    logic [HW-1:0] holdCnt;
    logic          L_prev;
    logic          R_prev;
    logic          leftPress;
    logic          rightPress;

    assign leftPress  = L && !L_prev;
    assign rightPress = R && !R_prev;

    always_ff @(posedge Clock) begin
        if (RST) begin
            state       <= PLAY;
            pos         <= POS_CENTER;
            holdCnt     <= '0;
            left_score  <= '0;
            right_score <= '0;
            // Treat keys as already down so one held through reset cannot fire.
            L_prev      <= 1'b1;
            R_prev      <= 1'b1;
        end else begin
            L_prev <= L;
            R_prev <= R;
            case (state)
                PLAY: begin
                    if (leftPress && !rightPress) begin
                        if (pos == POS_MAX) begin
                            state   <= WIN_L;
                            holdCnt <= '0;
                            if (left_score != SCORE_MAX)
                                left_score <= left_score + SCORE_W'(1);
                        end else begin
                            pos <= pos + PW'(1);
                        end
                    end else if (rightPress && !leftPress) begin
                        if (pos == '0) begin
                            state   <= WIN_R;
                            holdCnt <= '0;
                            if (right_score != SCORE_MAX)
                                right_score <= right_score + SCORE_W'(1);
                        end else begin
                            pos <= pos - PW'(1);
                        end
                    end
                end
                WIN_L, WIN_R: begin
                    if (holdCnt == HOLD_LAST) begin
                        state   <= PLAY;
                        pos     <= POS_CENTER;
                        holdCnt <= '0;
                    end else begin
                        holdCnt <= holdCnt + HW'(1);
                    end
                end
                default: begin
                    state <= PLAY;
                    pos   <= POS_CENTER;
                end
            endcase
        end
    end

    // Outputs depend only on registered state; L and R never reach them directly.
    always_comb begin
        lights    = '1;
        winner    = 2'b00;
        game_over = 1'b0;
        case (state)
            PLAY: begin
                lights = N_LIGHTS'(1) << pos;
            end
            WIN_L: begin
                winner    = 2'b10;
                game_over = 1'b1;
            end
            WIN_R: begin
                winner    = 2'b01;
                game_over = 1'b1;
            end
            default: begin
                lights = '0;
            end
        endcase
    end

    assign dbgState = state;

endmodule

// File: tb/tb_light_track.sv
// Directed bench for light_track with N_LIGHTS=9, SCORE_W=3, WIN_HOLD=4;
// expected values are hand-computed from the game rules.
module tb_light_track;

    logic       Clock;
    logic       RST;
    logic       L;
    logic       R;
    logic [8:0] lights;
    logic [1:0] winner;
    logic       game_over;
    logic [2:0] left_score;
    logic [2:0] right_score;
    logic [1:0] dbgState;

    int vectors;
    int miscompares;

    light_track #(
        .N_LIGHTS(9),
        .SCORE_W (3),
        .WIN_HOLD(4)
    ) dut (
        .Clock      (Clock),
        .RST        (RST),
        .L          (L),
        .R          (R),
        .lights     (lights),
        .winner     (winner),
        .game_over  (game_over),
        .left_score (left_score),
        .right_score(right_score),
        .dbgState   (dbgState)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic pulse_l();
        L = 1'b1;
        tick();
        L = 1'b0;
        tick();
    endtask

    task automatic pulse_r();
        R = 1'b1;
        tick();
        R = 1'b0;
        tick();
    endtask

    // From centre: four steps to the left edge, a fifth press wins, then the hold.
    task automatic win_left(input logic [2:0] exp_score);
        for (int i = 0; i < 4; i++) pulse_l();
        L = 1'b1;
        tick();
        check("winL_winner", winner, 2'b10);
        check("winL_score", left_score, exp_score);
        L = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("winL_return", lights, 9'b000010000);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST = 1'b1;
        L   = 1'b0;
        R   = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        check("rst_lights", lights, 9'b000010000);
        check("rst_winner", winner, 2'b00);
        check("rst_gameover", game_over, 1'b0);
        check("rst_lscore", left_score, 3'd0);
        check("rst_rscore", right_score, 3'd0);
        tick();

        // single press moves one step; holding gives nothing more
        L = 1'b1;
        tick();
        check("l_step", lights, 9'b000100000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("l_held", lights, 9'b000100000);
        end
        L = 1'b0;
        tick();
        pulse_r();
        check("back_center", lights, 9'b000010000);

        // simultaneous presses cancel
        L = 1'b1;
        R = 1'b1;
        tick();
        check("both_lights", lights, 9'b000010000);
        check("both_lscore", left_score, 3'd0);
        check("both_rscore", right_score, 3'd0);
        L = 1'b0;
        R = 1'b0;
        tick();

        // right player walks to the edge and wins
        for (int i = 0; i < 3; i++) pulse_r();
        R = 1'b1;
        tick();
        check("r_edge", lights, 9'b000000001);
        R = 1'b0;
        tick();
        R = 1'b1;
        tick();
        R = 1'b0;
        check("winR_state", dbgState, 2'b10);
        check("winR_lights", lights, 9'b111111111);
        check("winR_score", right_score, 3'd1);
        for (int i = 0; i < 4; i++) begin
            check("winR_hold_go", game_over, 1'b1);
            check("winR_hold_winner", winner, 2'b01);
            L = (i == 1) ? 1'b1 : 1'b0;
            tick();
        end
        L = 1'b0;
        check("winR_end_go", game_over, 1'b0);
        check("winR_end_lights", lights, 9'b000010000);
        check("winR_end_rscore", right_score, 3'd1);
        check("winR_end_lscore", left_score, 3'd0);

        // left score saturates at 7, winner still reported
        for (int w = 1; w <= 8; w++) win_left((w > 7) ? 3'd7 : 3'(w));
        check("sat_rscore", right_score, 3'd1);

        // reset during the second hold cycle with L held down
        for (int i = 0; i < 4; i++) pulse_l();
        L = 1'b1;
        tick();
        check("pre_rst_go", game_over, 1'b1);
        tick();
        check("pre_rst_go2", game_over, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_go", game_over, 1'b0);
        check("mid_rst_winner", winner, 2'b00);
        check("mid_rst_lights", lights, 9'b000010000);
        check("mid_rst_lscore", left_score, 3'd0);
        check("mid_rst_rscore", right_score, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_through_rst", lights, 9'b000010000);
        end
        L = 1'b0;
        tick();
        L = 1'b1;
        tick();
        check("repress_after_rst", lights, 9'b000100000);
        L = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
